// File: rtl/aes_loader_pkg.sv
// Shared types and sizes for the AES byte-stream loader.
package aes_loader_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int AES_BITS    = 128;
  localparam int IDX_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_TEXT = 2'd1,
    HOLD      = 2'd2
  } state_e;

endpackage

// File: rtl/aes_loader_byte_assembler.sv
// Byte-indexed shadow register; o_data already carries the byte being written
// this cycle so the owner can capture a complete block on the final transfer.
module byte_assembler #(
  parameter int NBYTES = 16,
  parameter int IDX_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [7:0]            i_byte,
  output logic [0:8*NBYTES-1]   o_data
);
  import aes_loader_pkg::*;

  logic [0:8*NBYTES-1] r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_shadow <= '0;
    end else if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_idx == IDX_W'(b)) r_shadow[8*b +: 8] <= i_byte;
      end
    end
  end

  always_comb begin
    o_data = r_shadow;
    if (i_we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (i_idx == IDX_W'(b)) o_data[8*b +: 8] = i_byte;
      end
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Byte-serial loader that assembles an AES key and plaintext blocks (MSB byte
// first) and holds each completed text block until the consumer acknowledges.
//
// state     | meaning
// LOAD_KEY  | collecting key bytes, key_valid low
// LOAD_TEXT | key held, collecting plaintext bytes
// HOLD      | text block presented, waiting for block_ack, no bytes accepted
module aes_block_loader #(
  parameter int BLOCK_BYTES = aes_loader_pkg::BLOCK_BYTES,
  parameter int CNT_W       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [7:0]                 i_in_byte,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic                       i_new_key,
  input  logic                       i_block_ack,
  output logic [0:8*BLOCK_BYTES-1]   o_key_out,
  output logic [0:8*BLOCK_BYTES-1]   o_text_out,
  output logic                       o_key_valid,
  output logic                       o_block_valid,
  output logic [CNT_W-1:0]           o_blk_count
);
  import aes_loader_pkg::*;

  localparam int IDX_BITS = $clog2(BLOCK_BYTES);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BLOCK_BYTES - 1);

  state_e                    r_state, w_state_nxt;
  logic [IDX_BITS-1:0]       r_idx;
  logic [0:8*BLOCK_BYTES-1]  r_key_out, r_text_out;
  logic                      r_key_valid, r_block_valid;
  logic [CNT_W-1:0]          r_blk_count;

  logic                      w_xfer, w_last, w_key_we, w_text_we, w_ack;
  logic [0:8*BLOCK_BYTES-1]  w_key_data, w_text_data;

  // new_key wins over a same-cycle transfer, so the byte never reaches a shadow
  assign o_in_ready = (r_state != HOLD);
  assign w_xfer     = i_in_valid && o_in_ready && !i_new_key;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_key_we   = w_xfer && (r_state == LOAD_KEY);
  assign w_text_we  = w_xfer && (r_state == LOAD_TEXT);
  assign w_ack      = i_block_ack && (r_state == HOLD) && !i_new_key;

  byte_assembler #(.NBYTES(BLOCK_BYTES), .IDX_W(IDX_BITS)) u_key_asm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_new_key),
    .i_we   (w_key_we),
    .i_idx  (r_idx),
    .i_byte (i_in_byte),
    .o_data (w_key_data)
  );

  byte_assembler #(.NBYTES(BLOCK_BYTES), .IDX_W(IDX_BITS)) u_text_asm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (i_new_key),
    .i_we   (w_text_we),
    .i_idx  (r_idx),
    .i_byte (i_in_byte),
    .o_data (w_text_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (i_new_key) begin
      w_state_nxt = LOAD_KEY;
    end else begin
      case (r_state)
        LOAD_KEY:  if (w_xfer && w_last) w_state_nxt = LOAD_TEXT;
        LOAD_TEXT: if (w_xfer && w_last) w_state_nxt = HOLD;
        HOLD:      if (w_ack) w_state_nxt = LOAD_TEXT;
        default:   w_state_nxt = LOAD_KEY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= LOAD_KEY;
      r_idx         <= '0;
      r_key_out     <= '0;
      r_text_out    <= '0;
      r_key_valid   <= 1'b0;
      r_block_valid <= 1'b0;
      r_blk_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_new_key) begin
        r_idx         <= '0;
        r_key_valid   <= 1'b0;
        r_block_valid <= 1'b0;
      end else begin
        if (w_xfer) begin
          if (w_last) begin
            r_idx <= '0;
            if (r_state == LOAD_KEY) begin
              r_key_out   <= w_key_data;
              r_key_valid <= 1'b1;
            end else begin
              r_text_out    <= w_text_data;
              r_block_valid <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + IDX_BITS'(1);
          end
        end
        if (w_ack) begin
          r_block_valid <= 1'b0;
          r_blk_count   <= r_blk_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_key_out     = r_key_out;
  assign o_text_out    = r_text_out;
  assign o_key_valid   = r_key_valid;
  assign o_block_valid = r_block_valid;
  assign o_blk_count   = r_blk_count;

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: a 16-byte instance for the main flow
// and a 4-byte, 2-bit-counter instance for the counter wrap.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst, in_valid, new_key, block_ack;
  logic [7:0]   in_byte;
  logic         in_ready, key_valid, block_valid;
  logic [0:127] key_out, text_out;
  logic [15:0]  blk_count;

  logic         s_rst, s_in_valid, s_new_key, s_block_ack;
  logic [7:0]   s_in_byte;
  logic         s_in_ready, s_key_valid, s_block_valid;
  logic [0:31]  s_key_out, s_text_out;
  logic [1:0]   s_blk_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_key_q[$];
  logic [127:0] exp_text_q[$];
  logic prev_kv = 1'b0, prev_bv = 1'b0;

  localparam logic [127:0] KEY_A  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_B  = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] TEXT_A = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_block_loader dut (
    .i_clk(clk), .i_rst(rst), .i_in_byte(in_byte), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_new_key(new_key), .i_block_ack(block_ack),
    .o_key_out(key_out), .o_text_out(text_out), .o_key_valid(key_valid),
    .o_block_valid(block_valid), .o_blk_count(blk_count)
  );

  aes_block_loader #(.BLOCK_BYTES(4), .CNT_W(2)) dut_small (
    .i_clk(clk), .i_rst(s_rst), .i_in_byte(s_in_byte), .i_in_valid(s_in_valid),
    .o_in_ready(s_in_ready), .i_new_key(s_new_key), .i_block_ack(s_block_ack),
    .o_key_out(s_key_out), .o_text_out(s_text_out), .o_key_valid(s_key_valid),
    .o_block_valid(s_block_valid), .o_blk_count(s_blk_count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares against the scoreboard whenever a key or block appears.
  always @(negedge clk) begin
    if (key_valid === 1'b1 && !prev_kv) begin
      if (exp_key_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL key_unexpected: got %h expected no key", key_out);
      end else chk("key_out", key_out, exp_key_q.pop_front());
    end
    if (block_valid === 1'b1 && !prev_bv) begin
      if (exp_text_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL text_unexpected: got %h expected no block", text_out);
      end else chk("text_out", text_out, exp_text_q.pop_front());
      chk("ready_in_hold", 128'(in_ready), 128'd0);
    end
    prev_kv = (key_valid === 1'b1);
    prev_bv = (block_valid === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_block(input logic [127:0] blk);
    for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8]);
  endtask

  task automatic pulse_ack;
    in_valid  = 1'b0;
    block_ack = 1'b1;
    @(negedge clk);
    block_ack = 1'b0;
  endtask

  initial begin
    logic [127:0] blk;
    logic [31:0]  s_exp;
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; new_key = 1'b0; block_ack = 1'b0;
    s_rst = 1'b1; s_in_valid = 1'b0; s_in_byte = 8'h00; s_new_key = 1'b0; s_block_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;

    chk("rst_key_out",     key_out,            128'd0);
    chk("rst_text_out",    text_out,           128'd0);
    chk("rst_key_valid",   128'(key_valid),    128'd0);
    chk("rst_block_valid", 128'(block_valid),  128'd0);
    chk("rst_blk_count",   128'(blk_count),    128'd0);
    chk("rst_in_ready",    128'(in_ready),     128'd1);

    // continuous key then text, in_valid held high
    exp_key_q.push_back(KEY_A);
    send_block(KEY_A);
    chk("key_valid_after_key", 128'(key_valid), 128'd1);
    exp_text_q.push_back(TEXT_A);
    for (int i = 0; i < 15; i++) send_byte(TEXT_A[127-8*i -: 8]);
    chk("bv_before_last", 128'(block_valid), 128'd0);
    send_byte(TEXT_A[7:0]);
    chk("bv_latency", 128'(block_valid), 128'd1);

    // source keeps offering AA during HOLD
    in_byte = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", 128'(in_ready), 128'd0);
    end
    chk("hold_text_stable", text_out, TEXT_A);
    pulse_ack();
    chk("ack_blk_count",   128'(blk_count),   128'd1);
    chk("ack_block_valid", 128'(block_valid), 128'd0);
    chk("ack_key_valid",   128'(key_valid),   128'd1);
    chk("ack_ready",       128'(in_ready),    128'd1);

    // gapped text: 1 valid, 2 idle, starting right after the ack
    exp_text_q.push_back(TEXT_A);
    for (int i = 0; i < 16; i++) begin
      send_byte(TEXT_A[127-8*i -: 8]);
      in_valid = 1'b0;
      in_byte  = 8'hEE;
      if (i < 15) chk("gap_bv_low", 128'(block_valid), 128'd0);
      repeat (2) @(negedge clk);
    end
    chk("gap_bv_high", 128'(block_valid), 128'd1);
    pulse_ack();
    chk("gap_blk_count", 128'(blk_count), 128'd2);

    // new_key after 7 text bytes, with a byte offered in the same cycle
    for (int i = 0; i < 7; i++) send_byte(TEXT_A[127-8*i -: 8]);
    in_byte = 8'h77; in_valid = 1'b1; new_key = 1'b1;
    @(negedge clk);
    new_key = 1'b0; in_valid = 1'b0;
    chk("nk_key_valid",  128'(key_valid),   128'd0);
    chk("nk_bv",         128'(block_valid), 128'd0);
    chk("nk_key_kept",   key_out,           KEY_A);
    chk("nk_text_kept",  text_out,          TEXT_A);
    chk("nk_blk_count",  128'(blk_count),   128'd2);
    exp_key_q.push_back(KEY_B);
    send_block(KEY_B);
    exp_text_q.push_back(128'd0);
    send_block(128'd0);
    chk("nk_block_valid", 128'(block_valid), 128'd1);

    // ack and new_key together in HOLD
    in_valid = 1'b0; block_ack = 1'b1; new_key = 1'b1;
    @(negedge clk);
    block_ack = 1'b0; new_key = 1'b0;
    chk("acknk_blk_count", 128'(blk_count),   128'd2);
    chk("acknk_bv",        128'(block_valid), 128'd0);
    chk("acknk_key_valid", 128'(key_valid),   128'd0);
    chk("acknk_ready",     128'(in_ready),    128'd1);

    // reset in the middle of a key
    for (int i = 0; i < 5; i++) send_byte(8'h55);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_key_out",   key_out,           128'd0);
    chk("mrst_text_out",  text_out,          128'd0);
    chk("mrst_key_valid", 128'(key_valid),   128'd0);
    chk("mrst_bv",        128'(block_valid), 128'd0);
    chk("mrst_blk_count", 128'(blk_count),   128'd0);
    exp_key_q.push_back(KEY_A);
    send_block(KEY_A);
    in_valid = 1'b0;
    @(negedge clk);

    // counter wrap on the small instance
    for (int i = 0; i < 4; i++) begin
      s_in_byte = 8'(8'hC0 + i); s_in_valid = 1'b1;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    chk("small_key", 128'(s_key_out), 128'hc0c1c2c3);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        s_in_byte = 8'(4*k + i); s_in_valid = 1'b1;
        @(negedge clk);
      end
      s_in_valid = 1'b0;
      s_exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      chk("small_bv",   128'(s_block_valid), 128'd1);
      chk("small_text", 128'(s_text_out),    128'(s_exp));
      s_block_ack = 1'b1;
      @(negedge clk);
      s_block_ack = 1'b0;
      chk("small_count", 128'(s_blk_count), 128'((k + 1) % 4));
    end

    chk("key_q_drained",  128'(exp_key_q.size()),  128'd0);
    chk("text_q_drained", 128'(exp_text_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
